// File: rtl/fpga_rst_pkg.sv
// rtl/fpga_rst_pkg.sv - state encoding and reset-cause codes for the board reset sequencer
package fpga_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
    localparam logic [1:0] RST_CAUSE_BTN  = 2'b01;
    localparam logic [1:0] RST_CAUSE_PLL  = 2'b10;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b11;

endpackage

// File: rtl/rst_debounce.sv
// rtl/rst_debounce.sv - button synchroniser chain and debounce counter
module rst_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_rst_n_i,
    output logic btn_db_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Shift the raw button into the synchroniser; resets to released so no spurious press appears.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_rst_n_i};
        end
    end

    // Accept a new button level only after it has persisted for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            btn_db_o <= 1'b1;
            db_cnt   <= '0;
        end else if (btn_s == btn_db_o) begin
            db_cnt   <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_o <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_rst_seq.sv
// rtl/fpga_rst_seq.sv - board reset sequencer driving the SoC reset pin
module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_rst_n_i,
    input  logic       pll_locked_i,
    input  logic       soft_rst_req_i,
    output logic       soc_rst_n_o,
    output logic [1:0] rst_cause_o,
    output logic       btn_db_o
);

    logic [SYNC_STAGES-1:0] lock_q;
    logic                   lock_s;
    logic [CNT_W-1:0]       hold_cnt;
    state_t                 state;

    assign lock_s = lock_q[SYNC_STAGES-1];

    rst_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .btn_rst_n_i (btn_rst_n_i),
        .btn_db_o    (btn_db_o)
    );

    // Synchronise the PLL lock flag; resets to unlocked.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock_q <= '0;
        end else begin
            lock_q <= {lock_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    // Sequencer FSM; soc_rst_n_o is registered high only on edges that land in RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            soc_rst_n_o <= 1'b0;
            rst_cause_o <= RST_CAUSE_POR;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    hold_cnt    <= '0;
                    soc_rst_n_o <= 1'b0;
                    if (lock_s) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    soc_rst_n_o <= 1'b0;
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        hold_cnt    <= '0;
                        rst_cause_o <= RST_CAUSE_PLL;
                    end else if (!btn_db_o) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state       <= RUN;
                        soc_rst_n_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        hold_cnt    <= '0;
                        soc_rst_n_o <= 1'b0;
                        rst_cause_o <= RST_CAUSE_PLL;
                    end else if (!btn_db_o) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        soc_rst_n_o <= 1'b0;
                        rst_cause_o <= RST_CAUSE_BTN;
                    end else if (soft_rst_req_i) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        soc_rst_n_o <= 1'b0;
                        rst_cause_o <= RST_CAUSE_SOFT;
                    end else begin
                        soc_rst_n_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    hold_cnt    <= '0;
                    soc_rst_n_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb/tb_fpga_rst_seq.sv - directed scoreboard bench for fpga_rst_seq
module tb_fpga_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       btn_rst_n_i;
    logic       pll_locked_i;
    logic       soft_rst_req_i;
    logic       soc_rst_n_o;
    logic [1:0] rst_cause_o;
    logic       btn_db_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic       soc;
        logic [1:0] cause;
        logic       db;
    } exp_t;

    exp_t sb[$];

    fpga_rst_seq #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .CNT_W           (20)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .btn_rst_n_i    (btn_rst_n_i),
        .pll_locked_i   (pll_locked_i),
        .soft_rst_req_i (soft_rst_req_i),
        .soc_rst_n_o    (soc_rst_n_o),
        .rst_cause_o    (rst_cause_o),
        .btn_db_o       (btn_db_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_out();
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests += 3;
            assert (soc_rst_n_o === e.soc) else begin
                fails++;
                $error("FAIL %s soc_rst_n observed=%b expected=%b", e.tag, soc_rst_n_o, e.soc);
            end
            assert (rst_cause_o === e.cause) else begin
                fails++;
                $error("FAIL %s rst_cause observed=%b expected=%b", e.tag, rst_cause_o, e.cause);
            end
            assert (btn_db_o === e.db) else begin
                fails++;
                $error("FAIL %s btn_db observed=%b expected=%b", e.tag, btn_db_o, e.db);
            end
        end
    endtask

    // push the expectation for the coming edge, advance one clock, sample 1 time unit later and compare
    task automatic step(input string tag, input logic soc, input logic [1:0] cause, input logic db);
        exp_t e;
        e.tag   = tag;
        e.soc   = soc;
        e.cause = cause;
        e.db    = db;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    initial begin
        rst_n_i        = 1'b0;
        btn_rst_n_i    = 1'b1;
        pll_locked_i   = 1'b1;
        soft_rst_req_i = 1'b0;
        #1;
        step("reset", 1'b0, 2'b00, 1'b1);
        step("reset", 1'b0, 2'b00, 1'b1);

        // power-on: rises after edge 11
        rst_n_i = 1'b1;
        for (int k = 1; k <= 12; k++) step("por", (k >= 11), 2'b00, 1'b1);

        // 3-cycle glitch is discarded
        btn_rst_n_i = 1'b0;
        for (int k = 1; k <= 3; k++) step("glitch", 1'b1, 2'b00, 1'b1);
        btn_rst_n_i = 1'b1;
        for (int k = 1; k <= 6; k++) step("glitch_after", 1'b1, 2'b00, 1'b1);

        // 20-cycle press: db falls after edge 6, soc after edge 7
        btn_rst_n_i = 1'b0;
        for (int k = 1; k <= 20; k++)
            step("press", (k < 7), (k >= 7) ? 2'b01 : 2'b00, (k < 6));
        btn_rst_n_i = 1'b1;
        for (int k = 1; k <= 16; k++) step("release", (k >= 14), 2'b01, (k >= 6));

        // soft reset at edge N=k1 with a second request ignored during HOLD
        for (int k = 1; k <= 10; k++) begin
            soft_rst_req_i = (k == 1 || k == 4);
            step("soft", (k >= 9), 2'b11, 1'b1);
        end
        soft_rst_req_i = 1'b0;

        // lock loss mid-HOLD
        soft_rst_req_i = 1'b1;
        step("soft2", 1'b0, 2'b11, 1'b1);
        soft_rst_req_i = 1'b0;
        for (int k = 1; k <= 3; k++) step("soft2_hold", 1'b0, 2'b11, 1'b1);
        pll_locked_i = 1'b0;
        for (int k = 1; k <= 5; k++) step("lock_loss", 1'b0, (k >= 3) ? 2'b10 : 2'b11, 1'b1);
        pll_locked_i = 1'b1;
        for (int k = 1; k <= 12; k++) step("relock", (k >= 11), 2'b10, 1'b1);

        // button falls on same edge as soft request: button wins
        btn_rst_n_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            soft_rst_req_i = (k == 7);
            step("btn_vs_soft", (k < 7), (k >= 7) ? 2'b01 : 2'b10, (k < 6));
        end
        soft_rst_req_i = 1'b0;
        btn_rst_n_i = 1'b1;
        for (int k = 1; k <= 16; k++) step("release2", (k >= 14), 2'b01, (k >= 6));

        // button falls on same edge lock is lost: lock wins
        btn_rst_n_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) pll_locked_i = 1'b0;
            step("btn_vs_lock", (k < 7), (k >= 7) ? 2'b10 : 2'b01, (k < 6));
        end
        btn_rst_n_i  = 1'b1;
        pll_locked_i = 1'b1;
        for (int k = 1; k <= 15; k++) step("relock2", (k >= 14), 2'b10, (k >= 6));

        // block reset mid-HOLD with hold_cnt=5
        soft_rst_req_i = 1'b1;
        step("soft3", 1'b0, 2'b11, 1'b1);
        soft_rst_req_i = 1'b0;
        for (int k = 1; k <= 5; k++) step("soft3_hold", 1'b0, 2'b11, 1'b1);
        rst_n_i = 1'b0;
        step("mid_reset", 1'b0, 2'b00, 1'b1);
        step("mid_reset", 1'b0, 2'b00, 1'b1);
        rst_n_i = 1'b1;
        for (int k = 1; k <= 12; k++) step("por2", (k >= 11), 2'b00, 1'b1);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
